// File: rtl/accumulator_pkg.sv
// accumulator_pkg
//   Shared constants for the accumulator_4 datapath and its sequencers.
//   - C_HOLD/C_LOAD/C_ADD/C_CLR : accumulator_4 control codes (i_C)
//   - state_t                   : multiplier sequencer states
//   - DEF_W                     : default operand / accumulator width
package accumulator_pkg;

    localparam int DEF_W = 4;

    localparam logic [1:0] C_HOLD = 2'b00;  // Q, carry unchanged
    localparam logic [1:0] C_LOAD = 2'b01;  // Q <= D, carry <= 0
    localparam logic [1:0] C_ADD  = 2'b10;  // {carry,Q} <= Q + D
    localparam logic [1:0] C_CLR  = 2'b11;  // not used by the multiplier

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/accumulator_mult_ctrl.sv
// accumulator_mult_ctrl
//   Drives an external accumulator_4 to form A*B by repeated addition:
//   one LOAD of zero, then B adds of A. Carry-out is collected into a sticky
//   overflow flag; the low W bits and the flag are latched in CHECK and a
//   one-cycle done pulse follows.
//
// Ports
//   i_CLK, i_RST_N       clock (shared with accumulator_4), async active-low reset
//   i_START              run request, only looked at in IDLE
//   i_A, i_B             multiplicand / multiplier, captured on accepted start
//   i_Q, i_CARRY         accumulator_4 outputs
//   o_EN, o_C, o_D       accumulator_4 controls (Moore decode of state)
//   o_BUSY               high LOAD..CHECK
//   o_DONE               one-cycle pulse in DONE
//   o_RESULT, o_OVF      latched product low bits / product >= 2^W
module accumulator_mult_ctrl
    import accumulator_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_W     // must be >= W so the counter can hold B
) (
    input  logic         i_CLK,
    input  logic         i_RST_N,
    input  logic         i_START,
    input  logic [W-1:0] i_A,
    input  logic [W-1:0] i_B,
    input  logic [W-1:0] i_Q,
    input  logic         i_CARRY,
    output logic         o_EN,
    output logic [1:0]   o_C,
    output logic [W-1:0] o_D,
    output logic         o_BUSY,
    output logic         o_DONE,
    output logic [W-1:0] o_RESULT,
    output logic         o_OVF
);

    state_t             state, state_nxt;
    logic [W-1:0]       a_q, b_q;
    logic [CNT_W-1:0]   cnt;
    logic               first_add;  // carry seen in the first ADD is LOAD's, not an add's
    logic               sticky;

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_START) state_nxt = LOAD;
            LOAD:    state_nxt = (b_q != '0) ? ADD : CHECK;
            ADD:     if (cnt == CNT_W'(1)) state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- state + datapath registers ----------------
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            first_add <= 1'b0;
            sticky    <= 1'b0;
            o_RESULT  <= '0;
            o_OVF     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_START) begin
                        a_q    <= i_A;
                        b_q    <= i_B;
                        sticky <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt       <= CNT_W'(b_q);
                    first_add <= 1'b1;
                end
                ADD: begin
                    cnt       <= cnt - CNT_W'(1);
                    first_add <= 1'b0;
                    // i_CARRY lags by one cycle: it is the carry of the previous add
                    if (!first_add)
                        sticky <= sticky | i_CARRY;
                end
                CHECK: begin
                    // here i_CARRY belongs to the final add; with B==0 no add ran
                    o_RESULT <= i_Q;
                    o_OVF    <= sticky | ((b_q != '0) & i_CARRY);
                end
                default: ;
            endcase
        end
    end

    // ---------------- Moore output decode ----------------
    always_comb begin
        o_EN   = 1'b0;
        o_C    = C_HOLD;
        o_D    = '0;
        o_BUSY = 1'b0;
        o_DONE = 1'b0;
        case (state)
            LOAD: begin
                o_EN   = 1'b1;
                o_C    = C_LOAD;
                o_BUSY = 1'b1;
            end
            ADD: begin
                o_EN   = 1'b1;
                o_C    = C_ADD;
                o_D    = a_q;
                o_BUSY = 1'b1;
            end
            CHECK:   o_BUSY = 1'b1;
            DONE:    o_DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_accumulator_mult_ctrl.sv
module tb_accumulator_mult_ctrl;
    import accumulator_pkg::*;

    logic       i_CLK, i_RST_N, i_START, i_CARRY;
    logic [3:0] i_A, i_B, i_Q;
    logic       o_EN, o_BUSY, o_DONE, o_OVF;
    logic [1:0] o_C;
    logic [3:0] o_D, o_RESULT;

    int n_chk  = 0;
    int n_fail = 0;

    accumulator_mult_ctrl #(.W(4), .CNT_W(4)) dut (
        .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_START(i_START),
        .i_A(i_A), .i_B(i_B), .i_Q(i_Q), .i_CARRY(i_CARRY),
        .o_EN(o_EN), .o_C(o_C), .o_D(o_D), .o_BUSY(o_BUSY),
        .o_DONE(o_DONE), .o_RESULT(o_RESULT), .o_OVF(o_OVF)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // behavioural accumulator_4
    always @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            i_Q     <= 4'h0;
            i_CARRY <= 1'b0;
        end else if (o_EN) begin
            case (o_C)
                C_LOAD: begin i_Q <= o_D; i_CARRY <= 1'b0; end
                C_ADD:  {i_CARRY, i_Q} <= {1'b0, i_Q} + {1'b0, o_D};
                C_CLR:  begin i_Q <= 4'h0; i_CARRY <= 1'b0; end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // START high for cycle 0; returns at the negedge of cycle 1
    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b);
        @(negedge i_CLK);
        i_A = a; i_B = b; i_START = 1'b1;
        @(negedge i_CLK);
        i_START = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (o_DONE !== 1'b1 && cyc < from + 40) begin
            @(negedge i_CLK);
            cyc++;
        end
    endtask

    // full run with per-cycle schedule check, then result check in DONE
    task automatic run_sched(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] res, input logic ovf);
        pulse_start(a, b);
        chk({tag, " load_en"}, o_EN, 1);
        chk({tag, " load_c"}, o_C, C_LOAD);
        chk({tag, " load_d"}, o_D, 0);
        chk({tag, " load_busy"}, o_BUSY, 1);
        for (int i = 0; i < int'(b); i++) begin
            @(negedge i_CLK);
            chk({tag, " add_en"}, o_EN, 1);
            chk({tag, " add_c"}, o_C, C_ADD);
            chk({tag, " add_d"}, o_D, a);
        end
        @(negedge i_CLK);
        chk({tag, " check_en"}, o_EN, 0);
        chk({tag, " check_busy"}, o_BUSY, 1);
        chk({tag, " check_done"}, o_DONE, 0);
        @(negedge i_CLK);
        chk({tag, " done"}, o_DONE, 1);
        chk({tag, " done_busy"}, o_BUSY, 0);
        chk({tag, " result"}, o_RESULT, res);
        chk({tag, " ovf"}, o_OVF, ovf);
        @(negedge i_CLK);
        chk({tag, " done_pulse"}, o_DONE, 0);
    endtask

    initial begin
        int cyc;
        int dones;
        i_RST_N = 1'b0; i_START = 1'b0; i_A = 4'h0; i_B = 4'h0;
        #1;
        chk("rst en", o_EN, 0);
        chk("rst c", o_C, C_HOLD);
        chk("rst busy", o_BUSY, 0);
        chk("rst done", o_DONE, 0);
        chk("rst result", o_RESULT, 0);
        chk("rst ovf", o_OVF, 0);
        repeat (2) @(negedge i_CLK);
        i_RST_N = 1'b1;

        // basic product, wrap, boundaries, sticky carry
        run_sched("3x4", 4'd3, 4'd4, 4'hC, 1'b0);
        run_sched("5x4", 4'd5, 4'd4, 4'h4, 1'b1);
        run_sched("15x1", 4'd15, 4'd1, 4'hF, 1'b0);
        run_sched("7x0", 4'd7, 4'd0, 4'h0, 1'b0);
        run_sched("0x9", 4'd0, 4'd9, 4'h0, 1'b0);
        run_sched("9x2", 4'd9, 4'd2, 4'h2, 1'b1);
        run_sched("9x3", 4'd9, 4'd3, 4'hB, 1'b1);   // carry on 2nd add only, still flagged

        // START and operand change mid-run are ignored
        pulse_start(4'd3, 4'd4);
        @(negedge i_CLK);                             // cycle 2, ADD
        i_START = 1'b1; i_A = 4'd9; i_B = 4'd2;
        @(negedge i_CLK);
        i_START = 1'b0;
        wait_done(3, cyc);
        chk("ignore latency", cyc, 7);
        chk("ignore result", o_RESULT, 4'hC);
        chk("ignore ovf", o_OVF, 0);
        @(negedge i_CLK);
        chk("ignore no_restart", o_BUSY, 0);

        // START held high: re-trigger right after DONE
        @(negedge i_CLK);
        i_A = 4'd2; i_B = 4'd1; i_START = 1'b1;       // cycle 0
        @(negedge i_CLK);
        wait_done(1, cyc);
        chk("held latency", cyc, 4);
        chk("held result1", o_RESULT, 4'h2);
        @(negedge i_CLK);
        chk("held idle", o_BUSY, 0);
        @(negedge i_CLK);
        chk("held reload busy", o_BUSY, 1);
        chk("held reload c", o_C, C_LOAD);
        i_START = 1'b0; i_A = 4'd5;
        wait_done(6, cyc);
        chk("held latency2", cyc, 9);
        chk("held result2", o_RESULT, 4'h2);

        // async reset in the middle of an ADD run
        @(negedge i_CLK);
        pulse_start(4'd3, 4'd6);                      // now cycle 1
        repeat (2) @(negedge i_CLK);                  // cycle 3
        @(posedge i_CLK);
        #2 i_RST_N = 1'b0;                            // cycle 4, between edges
        #1;
        chk("abort en", o_EN, 0);
        chk("abort busy", o_BUSY, 0);
        chk("abort c", o_C, C_HOLD);
        chk("abort result", o_RESULT, 0);
        chk("abort ovf", o_OVF, 0);
        @(negedge i_CLK);
        i_RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_CLK);
            if (o_DONE === 1'b1) dones++;
        end
        chk("abort no_done", dones, 0);
        run_sched("2x3", 4'd2, 4'd3, 4'h6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/accumulator_mult_ctrl.md
Name: accumulator_mult_ctrl

Overview:
- Sequencer that drives the 4-bit accumulator (accumulator_4) to compute an unsigned product A*B by repeated addition.
- Sits between the board-level top and accumulator_4, and owns that accumulator's i_EN, i_C and i_D.
- Accepts a start request, runs LOAD-0 followed by B ADD-A steps, tracks carry-out as a sticky overflow flag, and reports a latched result with a one-cycle done pulse.

Parameters:
- W, 4, data width of operands, accumulator and result.
- CNT_W, 4, width of the iteration counter; must be at least W.

Ports:
- i_CLK  in  1  clock; the same clock that drives accumulator_4.
- i_RST_N  in  1  reset, asynchronous assert, active-low.
- i_START  in  1  request; sampled only in IDLE.
- i_A  in  W  multiplicand; captured on accepted start.
- i_B  in  W  multiplier / iteration count; captured on accepted start.
- i_Q  in  W  accumulator output Q.
- i_CARRY  in  1  accumulator carry output.
- o_EN  out  1  accumulator enable.
- o_C  out  2  accumulator control code.
- o_D  out  W  accumulator data input.
- o_BUSY  out  1  high from LOAD through CHECK.
- o_DONE  out  1  one-cycle pulse in DONE.
- o_RESULT  out  W  latched low W bits of the product.
- o_OVF  out  1  latched flag: product >= 2^W.

Behaviour:
- Reset (async, i_RST_N=0): state=IDLE; all outputs 0; captured A, B, counter, sticky flag and result cleared. Reset asserted mid-operation aborts the run immediately, with no done pulse.
- Accumulator control codes (package constants): C_HOLD=2'b00, C_LOAD=2'b01 (Q<=D, carry<=0), C_ADD=2'b10 ({carry,Q}<=Q+D), C_CLR=2'b11 (unused).
- IDLE: o_EN=0, o_C=C_HOLD, o_D=0. If i_START=1, capture A and B, clear the sticky flag, go to LOAD.
- LOAD (1 cycle): o_EN=1, o_C=C_LOAD, o_D=0. Counter<=B. Next state is ADD if B!=0, else CHECK.
- ADD: o_EN=1, o_C=C_ADD, o_D=A. Counter decrements each cycle; leave for CHECK when counter==1. Every ADD cycle except the first ORs i_CARRY into the sticky flag, because carry reflects the previous add.
- CHECK (1 cycle): o_EN=0. OR i_CARRY into sticky, except when B==0. o_RESULT<=i_Q, o_OVF<=sticky|current sample.
- DONE (1 cycle): o_DONE=1, o_BUSY=0. Return to IDLE.
- Latency: with START sampled at cycle 0, DONE is asserted in cycle B+3. The accumulator performs exactly B adds.
- o_RESULT and o_OVF hold their values until the next CHECK, or until reset.
- i_START while BUSY or in DONE is ignored, with no queueing. START held high re-triggers from IDLE on the cycle after DONE.
- Width rule: the accumulator wraps mod 2^W. Overflow is sticky, so any carry in any add sets o_OVF even if later adds do not carry.
- The A=0 or B=0 boundary gives result 0 with o_OVF=0.
- i_A and i_B changes during a run have no effect; operands are used from the start-time capture.
- o_BUSY, o_DONE and the accumulator controls are registered-state decodes (Moore), so there are no combinational paths from i_START.

Decomposition:
- Package accumulator_pkg holds:
  - C_HOLD, C_LOAD, C_ADD, C_CLR localparams;
  - the state enum typedef (IDLE, LOAD, ADD, CHECK, DONE);
  - a default width constant of 4.
- No sub-module: a single FSM plus counter.
- accumulator_4 is instantiated alongside this block in the board top, not inside it.

Test Plan:
1. Reset then A=3, B=4, START at cycle 0 -> LOAD at cycle 1, four ADDs in cycles 2-5, CHECK at 6, o_DONE at 7; o_RESULT=4'hC, o_OVF=0.
2. A=5, B=4 -> o_RESULT=4'h4 (20 mod 16), o_OVF=1; also A=15, B=1 -> 4'hF, o_OVF=0.
3. A=7, B=0 -> no ADD cycles; o_DONE at cycle 3; o_RESULT=0, o_OVF=0. A=0, B=9 -> 9 adds, result 0, o_OVF=0.
4. START pulsed again during ADD with different A/B -> ignored; first result unchanged. START held high -> second run begins the cycle after DONE.
5. i_RST_N low mid-ADD (A=3, B=6, at cycle 4), asynchronous between edges -> outputs 0 immediately, o_EN=0, no o_DONE. A subsequent A=2, B=3 run yields 4'h6.
6. Bench with a behavioural accumulator_4 model: check o_EN/o_C/o_D against the schedule each cycle and the sticky carry (A=9, B=2 -> carry only on the 2nd add, o_OVF=1, result 4'h2).
